// File: rtl/intg_pkg.sv
// ============================================================================
//  Module      : intg_pkg
//  Description : Constants, state encoding and helpers shared by both ends of
//                the window integrator (integrator scale table and decoder).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intg_pkg;

    localparam int STEP   = 25;
    localparam int SUM_W  = 13;
    localparam int CODE_W = 4;
    localparam int CMAX   = (1 << CODE_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // Width able to hold a window's code total (nsamp codes of at most cmax).
    function automatic int q_width(input int nsamp, input int cmax);
        return $clog2(nsamp * cmax + 1);
    endfunction

    // Integrator mux value for one code; kept here so both ends share STEP.
    function automatic logic [SUM_W-1:0] scale_code(input logic [CODE_W-1:0] x);
        return SUM_W'(x) * SUM_W'(STEP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/intg_div_step.sv
// ============================================================================
//  Module      : intg_div_step
//  Description : Iterative divider, one compare/subtract of STEP per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intg_div_step #(
    parameter int STEP  = 25,
    parameter int SUM_W = 13,
    parameter int Q_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    output logic             done,
    output logic [Q_W-1:0]   quotient,
    output logic [SUM_W-1:0] remainder
);

    logic             r_busy_q, w_busy_d;
    logic [SUM_W-1:0] r_rem_q,  w_rem_d;
    logic [Q_W-1:0]   r_quo_q,  w_quo_d;
    logic             w_ge;

    assign w_ge = (r_rem_q >= SUM_W'(STEP));

    always_comb begin
        w_busy_d = r_busy_q;
        w_rem_d  = r_rem_q;
        w_quo_d  = r_quo_q;
        if (start) begin
            w_busy_d = 1'b1;
            w_rem_d  = dividend;
            w_quo_d  = '0;
        end else if (r_busy_q) begin
            if (w_ge) begin
                w_rem_d = r_rem_q - SUM_W'(STEP);
                w_quo_d = r_quo_q + Q_W'(1);
            end else begin
                w_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_q <= 1'b0;
            r_rem_q  <= '0;
            r_quo_q  <= '0;
        end else begin
            r_busy_q <= w_busy_d;
            r_rem_q  <= w_rem_d;
            r_quo_q  <= w_quo_d;
        end
    end

    // Done is flagged in the cycle the remainder first drops below STEP.
    assign done      = r_busy_q && !w_ge;
    assign quotient  = r_quo_q;
    assign remainder = r_rem_q;

endmodule

`default_nettype wire

// File: rtl/intg_decode.sv
// ============================================================================
//  Module      : intg_decode
//  Description : Window-sum decoder: divides a sum by STEP and emits NSAMP
//                greedily packed codes on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intg_decode #(
    parameter int NSAMP  = 8,
    parameter int STEP   = intg_pkg::STEP,
    parameter int SUM_W  = intg_pkg::SUM_W,
    parameter int CODE_W = intg_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SUM_W-1:0]  sum_in,
    input  logic              sum_valid,
    output logic              sum_ready,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              code_last,
    output logic              err_range,
    output logic              err_rem
);

    import intg_pkg::*;

    localparam int c_cmax  = (1 << CODE_W) - 1;
    localparam int c_q_w   = q_width(NSAMP, c_cmax);
    localparam int c_idx_w = $clog2(NSAMP);
    localparam logic [SUM_W-1:0] c_max_sum = SUM_W'(NSAMP * c_cmax * STEP);

    state_e               r_state_q, w_state_d;
    logic [c_q_w-1:0]     r_qleft_q, w_qleft_d;
    logic [c_idx_w-1:0]   r_idx_q,   w_idx_d;
    logic                 r_err_range_q, w_err_range_d;

    logic                 w_div_start;
    logic                 w_div_done;
    logic [c_q_w-1:0]     w_quo;
    logic [SUM_W-1:0]     w_rem;
    logic [CODE_W-1:0]    w_code;
    logic                 w_last;
    logic                 w_accept;

    intg_div_step #(
        .STEP  (STEP),
        .SUM_W (SUM_W),
        .Q_W   (c_q_w)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (sum_in),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_code   = (r_qleft_q > c_q_w'(c_cmax)) ? CODE_W'(c_cmax)
                                                   : r_qleft_q[CODE_W-1:0];
    assign w_last   = (r_idx_q == c_idx_w'(NSAMP - 1));
    assign w_accept = sum_valid && sum_ready;

    always_comb begin
        w_state_d     = r_state_q;
        w_qleft_d     = r_qleft_q;
        w_idx_d       = r_idx_q;
        w_err_range_d = 1'b0;
        w_div_start   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (sum_in > c_max_sum) begin
                        w_err_range_d = 1'b1;
                    end else begin
                        w_div_start = 1'b1;
                        w_state_d   = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_qleft_d = w_quo;
                    w_idx_d   = '0;
                    w_state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (code_ready) begin
                    w_qleft_d = r_qleft_q - c_q_w'(w_code);
                    w_idx_d   = r_idx_q + c_idx_w'(1);
                    if (w_last) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_qleft_q     <= '0;
            r_idx_q       <= '0;
            r_err_range_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_qleft_q     <= w_qleft_d;
            r_idx_q       <= w_idx_d;
            r_err_range_q <= w_err_range_d;
        end
    end

    // Outputs are forced low while reset is asserted, including that cycle.
    assign sum_ready  = !reset && (r_state_q == ST_IDLE);
    assign code_valid = !reset && (r_state_q == ST_EMIT);
    assign code_out   = code_valid ? w_code : '0;
    assign code_last  = code_valid && w_last;
    assign err_range  = !reset && r_err_range_q;
    assign err_rem    = !reset && (r_state_q == ST_DIV) && w_div_done && (w_rem != '0);

endmodule

`default_nettype wire

// File: tb/tb_intg_decode.sv
// ============================================================================
//  Module      : tb_intg_decode
//  Description : Self-checking bench for intg_decode with a window-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intg_decode;

    localparam int NSAMP = 8;
    localparam int STEP  = 25;
    localparam int CMAX  = 15;
    localparam int MAXS  = NSAMP * CMAX * STEP;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] sum_in;
    logic        sum_valid;
    logic        sum_ready;
    logic [3:0]  code_out;
    logic        code_valid;
    logic        code_ready;
    logic        code_last;
    logic        err_range;
    logic        err_rem;

    intg_decode #(.NSAMP(NSAMP)) dut (
        .clk        (clk),
        .reset      (reset),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_last  (code_last),
        .err_range  (err_range),
        .err_rem    (err_rem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Window model: a sum becomes (q+1) divide cycles, then a queue of codes.
    int cyc = 0;
    int div_left = 0;
    int m_rem = 0;
    int codes_q[$];
    bit range_pulse = 1'b0;
    bit nxt_range;
    int ql;

    always @(posedge clk) begin
        cyc++;
        nxt_range = 1'b0;
        if (reset) begin
            div_left = 0;
            m_rem    = 0;
            codes_q.delete();
        end else if (div_left == 0 && codes_q.size() == 0) begin
            if (sum_valid) begin
                if (int'(sum_in) > MAXS) begin
                    nxt_range = 1'b1;
                end else begin
                    ql       = int'(sum_in) / STEP;
                    m_rem    = int'(sum_in) % STEP;
                    div_left = ql + 1;
                    for (int i = 0; i < NSAMP; i++) begin
                        codes_q.push_back((ql > CMAX) ? CMAX : ql);
                        ql -= (ql > CMAX) ? CMAX : ql;
                    end
                end
            end
        end else if (div_left > 0) begin
            div_left--;
        end else if (code_ready) begin
            void'(codes_q.pop_front());
        end
        range_pulse = reset ? 1'b0 : nxt_range;
    end

    // Per-cycle comparison against the model.
    bit e_ready, e_valid, e_last, e_rem_p;
    always @(negedge clk) begin
        e_ready = !reset && div_left == 0 && codes_q.size() == 0;
        e_valid = !reset && div_left == 0 && codes_q.size() > 0;
        e_last  = e_valid && codes_q.size() == 1;
        e_rem_p = !reset && div_left == 1 && m_rem != 0;
        check("sum_ready",  int'(sum_ready),  int'(e_ready));
        check("code_valid", int'(code_valid), int'(e_valid));
        check("code_last",  int'(code_last),  int'(e_last));
        check("err_rem",    int'(err_rem),    int'(e_rem_p));
        check("err_range",  int'(err_range),  int'(!reset && range_pulse));
        if (e_valid)
            check("code_out", int'(code_out), codes_q[0]);
        else if (reset)
            check("code_out_rst", int'(code_out), 0);
    end

    // Window statistics for the hand-computed expectations.
    int got[$];
    int t_acc, first_valid, last_hs, ready_after;
    int n_last, n_erem, n_erange, n_valid;

    always @(negedge clk) begin
        if (sum_valid && sum_ready && t_acc < 0) t_acc = cyc;
        if (code_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
            if (code_ready) begin
                got.push_back(int'(code_out));
                last_hs = cyc;
            end
        end
        if (sum_ready && last_hs >= 0 && ready_after < 0) ready_after = cyc;
        if (code_last) n_last += code_ready ? 1 : 0;
        if (err_rem)   n_erem++;
        if (err_range) n_erange++;
    end

    task automatic clear_stats();
        got.delete();
        t_acc = -1; first_valid = -1; last_hs = -1; ready_after = -1;
        n_last = 0; n_erem = 0; n_erange = 0; n_valid = 0;
    endtask

    task automatic send(input int s, input bit toggle, input int ncodes);
        clear_stats();
        @(posedge clk); #1;
        sum_in     = 13'(s);
        sum_valid  = 1'b1;
        code_ready = !toggle;
        for (int i = 0; i < 50 && t_acc < 0; i++) @(posedge clk);
        #1 sum_valid = 1'b0;
        if (ncodes == 0) begin
            for (int i = 0; i < 10; i++) @(posedge clk);
        end else begin
            for (int i = 0; i < 400 && got.size() < ncodes; i++) begin
                @(posedge clk); #1;
                if (toggle) code_ready = !code_ready;
            end
            check("window_done", got.size(), ncodes);
            code_ready = 1'b1;
            for (int i = 0; i < 3; i++) @(posedge clk);
        end
        #1;
    endtask

    task automatic check_codes(input string nm, input int e0, input int e1, input int e2, input int erest);
        int exp_c[NSAMP];
        exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2;
        for (int i = 3; i < NSAMP; i++) exp_c[i] = erest;
        check({nm, "_count"}, got.size(), NSAMP);
        for (int i = 0; i < NSAMP && i < got.size(); i++)
            check($sformatf("%s_code%0d", nm, i), got[i], exp_c[i]);
    endtask

    initial begin
        reset = 1'b1; sum_in = '0; sum_valid = 1'b0; code_ready = 1'b1;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sum_ready", int'(sum_ready), 0);
        check("reset_code_valid", int'(code_valid), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", int'(sum_ready), 1);

        send(375, 1'b0, NSAMP);
        check_codes("s375", 15, 0, 0, 0);
        check("s375_latency", first_valid - t_acc, 17);
        check("s375_last", n_last, 1);
        check("s375_errs", n_erem + n_erange, 0);

        send(1000, 1'b0, NSAMP);
        check_codes("s1000", 15, 15, 10, 0);
        check("s1000_latency", first_valid - t_acc, 42);

        send(3000, 1'b0, NSAMP);
        check_codes("s3000", 15, 15, 15, 15);
        check("s3000_latency", first_valid - t_acc, 122);
        check("s3000_ready_back", ready_after - last_hs, 1);

        send(3001, 1'b0, 0);
        check("s3001_err_range", n_erange, 1);
        check("s3001_no_valid", n_valid, 0);

        send(130, 1'b1, NSAMP);
        check_codes("s130", 5, 0, 0, 0);
        check("s130_err_rem", n_erem, 1);
        check("s130_last", n_last, 1);

        // Abandon a window mid-emit with a one-cycle reset.
        clear_stats();
        @(posedge clk); #1;
        sum_in = 13'd1000; sum_valid = 1'b1; code_ready = 1'b1;
        @(posedge clk); #1 sum_valid = 1'b0;
        for (int i = 0; i < 200 && got.size() < 3; i++) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_emit_valid", int'(code_valid), 0);
        check("rst_emit_ready", int'(sum_ready), 0);
        check("rst_emit_codes", got.size(), 3);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        check("rst_emit_no_last", n_last, 0);

        send(50, 1'b0, NSAMP);
        check_codes("s50", 2, 0, 0, 0);
        check("s50_last", n_last, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
